hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit_if.sv | 18 +
 rtl/hilo_muldiv_unit.sv | 100 ++++++++++
 tb/tb_hilo_muldiv_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: request/result bundle between datapath control and the Hi/Lo mul/div unit
// master: drives start/op/a/b and the mt_hi/mt_lo/mt_data writes; slave: returns busy/done/div_by_zero/hi/lo
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, mt_hi, mt_lo, mt_data, input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, a, b, mt_hi, mt_lo, mt_data, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU (one bit per clock) owning the Hi/Lo registers
// clk, rst_n (async active-low); bus: start/op/a/b request, mt_hi/mt_lo/mt_data writes,
// busy/done/div_by_zero status and hi/lo results
module hilo_muldiv_unit #(
  parameter int WIDTH         = 32,
  parameter bit ZERO_DIV_FAST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dv, hi_r, lo_r;
  logic [CW-1:0]      cnt;
  logic               sa, sb, sgn, is_div, busy_r, done_r, dbz_r;
  logic               a_neg, b_neg, ge, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   a_mag, b_mag, diff, quo, rem;
  logic [WIDTH:0]     madd, rem_sh;
  logic [2*WIDTH-1:0] mstep, dstep, prod;
  assign a_neg  = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg  = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;
  // multiply: low half holds the remaining multiplier bits, product grows in from the top
  assign madd   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : '0);
  assign mstep  = {madd, acc[WIDTH-1:1]};
  // divide: partial remainder shifted left by one; the difference always fits WIDTH bits when ge
  assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
  assign ge     = rem_sh >= {1'b0, dv};
  assign diff   = rem_sh[WIDTH-1:0] - dv;
  assign dstep  = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
  // -2^(W-1)/-1 lands on 2^(W-1) unnegated, which is the required wrap
  assign neg_q  = sgn & (sa ^ sb);
  assign neg_r  = sgn & sa;
  assign prod   = neg_q ? -acc : acc;
  assign quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign dz     = is_div & (dv == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      dv     <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      sgn    <= 1'b0;
      is_div <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mt_hi) hi_r <= bus.mt_data;
          if (bus.mt_lo) lo_r <= bus.mt_data;
          if (bus.start) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            dv     <= b_mag;
            sa     <= a_neg;
            sb     <= b_neg;
            sgn    <= ~bus.op[0];
            is_div <= bus.op[1];
            cnt    <= CW'(WIDTH);
            dbz_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= (ZERO_DIV_FAST && bus.op[1] && bus.b == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          acc <= is_div ? dstep : mstep;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) dbz_r <= 1'b1;
          else if (is_div) begin
            hi_r <= rem;
            lo_r <= quo;
          end else {hi_r, lo_r} <= prod;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors, expected results queued at issue and checked by a done monitor
module tb_hilo_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hilo_muldiv_unit_if #(.WIDTH(32)) io();
  hilo_muldiv_unit #(.WIDTH(32), .ZERO_DIV_FAST(1'b1)) dut(.clk(clk), .rst_n(rst_n), .bus(io));
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz; string nm;} exp_t;
  exp_t sbq[$];
  int cmp = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && io.done) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.nm, "_hi"}, io.hi, e.hi);
        chk({e.nm, "_lo"}, io.lo, e.lo);
        chk({e.nm, "_dbz"}, {31'd0, io.div_by_zero}, {31'd0, e.dbz});
      end
    end
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input string nm, input int want_lat);
    int lat;
    sbq.push_back('{eh, el, ed, nm});
    @(negedge clk);
    io.start = 1'b1;
    io.op = o;
    io.a = x;
    io.b = y;
    @(negedge clk);
    io.start = 1'b0;
    chk({nm, "_busy_start"}, {31'd0, io.busy}, 32'd1);
    chk({nm, "_dbz_clear"}, {31'd0, io.div_by_zero}, 32'd0);
    lat = 0;
    while (!io.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, want_lat);
    chk({nm, "_busy_end"}, {31'd0, io.busy}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    io.start = 1'b0;
    io.op = 2'b00;
    io.a = '0;
    io.b = '0;
    io.mt_hi = 1'b0;
    io.mt_lo = 1'b0;
    io.mt_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", io.hi, 32'd0);
    chk("reset_lo", io.lo, 32'd0);
    chk("reset_busy", {31'd0, io.busy}, 32'd0);
    chk("reset_done", {31'd0, io.done}, 32'd0);
    chk("reset_dbz", {31'd0, io.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max", 33);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg", 33);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mult_minmin", 33);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg", 33);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7", 33);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_wrap", 33);
    @(negedge clk);
    io.mt_hi = 1'b1;
    io.mt_data = 32'h1234;
    @(negedge clk);
    io.mt_hi = 1'b0;
    chk("mthi_idle", io.hi, 32'h1234);
    chk("mthi_lo_kept", io.lo, 32'h8000_0000);
    issue(2'b10, 32'd5, 32'd0, 32'h1234, 32'h8000_0000, 1'b1, "div_zero", 1);
    repeat (2) @(negedge clk);
    chk("dbz_hold", {31'd0, io.div_by_zero}, 32'd1);
    fork
      issue(2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, "divu_busy_ignore", 33);
      begin
        repeat (11) @(negedge clk);
        io.start = 1'b1;
        io.op = 2'b01;
        io.a = 32'd3;
        io.b = 32'd3;
        io.mt_lo = 1'b1;
        io.mt_data = 32'hAA;
        @(negedge clk);
        io.start = 1'b0;
        io.mt_lo = 1'b0;
      end
    join
    @(negedge clk);
    io.mt_lo = 1'b1;
    io.mt_data = 32'hAA;
    @(negedge clk);
    io.mt_lo = 1'b0;
    chk("mtlo_idle", io.lo, 32'hAA);
    chk("mtlo_hi_kept", io.hi, 32'h0);
    @(negedge clk);
    io.mt_hi = 1'b1;
    io.mt_lo = 1'b1;
    io.mt_data = 32'h55;
    @(negedge clk);
    io.mt_hi = 1'b0;
    io.mt_lo = 1'b0;
    chk("mt_both_hi", io.hi, 32'h55);
    chk("mt_both_lo", io.lo, 32'h55);
    @(negedge clk);
    io.start = 1'b1;
    io.op = 2'b11;
    io.a = 32'd1000;
    io.b = 32'd3;
    @(negedge clk);
    io.start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, io.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, io.done}, 32'd0);
    chk("rst_mid_hi", io.hi, 32'd0);
    chk("rst_mid_lo", io.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "multu_after_rst", 33);
    @(negedge clk);
    if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
